// File: rtl/sigmul_sched.sv
// sigmul_sched: one shift-and-add significand multiplier shared by two
// requesters under round-robin arbitration. Each product takes NSIG+1
// multiply steps and is returned on a single result channel tagged with
// the id of the requester that issued it.
module sigmul_sched #(
  parameter int unsigned NSIG = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [NSIG:0]        req0_a,
  input  logic [NSIG:0]        req0_b,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [NSIG:0]        req1_a,
  input  logic [NSIG:0]        req1_b,
  output logic                 res_valid,
  input  logic                 res_ready,
  output logic [2*NSIG+1:0]    res_p,
  output logic                 res_id,
  output logic                 busy
);

  localparam int unsigned SW = NSIG + 1;
  localparam int unsigned PW = 2 * NSIG + 2;
  localparam int unsigned CW = $clog2(NSIG + 2);

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t          state, state_nx;
  logic [SW-1:0]   mcand, mplier;
  logic [PW-1:0]   acc;
  logic [CW-1:0]   cnt;
  logic            id, last;
  logic            grant0, grant1;
  logic            take0, take1;
  logic            step_last;

  // Round-robin grant: a lone valid wins; on contention the port other than last wins.
  always_comb begin
    grant0 = req0_valid & (~req1_valid | last);
    grant1 = req1_valid & (~req0_valid | ~last);
  end

  // Readies are gated by rst_n so nothing looks accepted while reset is held.
  assign req0_ready = rst_n & (state == IDLE) & grant0;
  assign req1_ready = rst_n & (state == IDLE) & grant1;
  assign take0      = req0_ready;
  assign take1      = req1_ready;
  assign step_last  = (cnt == CW'(NSIG));

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (take0 | take1) state_nx = MUL;
      MUL:     if (step_last)     state_nx = DONE;
      DONE:    if (res_ready)     state_nx = IDLE;
      default:                    state_nx = IDLE;
    endcase
  end

  // Operand capture on accept, then one shift-and-add step per edge in MUL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      id     <= 1'b0;
      last   <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (take0 | take1) begin
            mcand  <= take1 ? req1_a : req0_a;
            mplier <= take1 ? req1_b : req0_b;
            acc    <= '0;
            cnt    <= '0;
            id     <= take1;
            last   <= take1;
          end
        end
        MUL: begin
          if (mplier[0]) acc <= acc + (PW'(mcand) << cnt);
          mplier <= mplier >> 1;
          cnt    <= cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Outputs come straight from registers; acc is frozen once in DONE.
  assign res_valid = (state == DONE);
  assign res_p     = acc;
  assign res_id    = id;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_sigmul_sched.sv
// Directed and random checks for sigmul_sched: reset values, latency,
// round-robin order, backpressure hold, zero/identity operands, mid-op reset.
module tb_sigmul_sched;

  localparam int unsigned NSIG = 10;
  localparam int unsigned SW   = NSIG + 1;
  localparam int unsigned PW   = 2 * NSIG + 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_ready, req1_ready;
  logic [SW-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic          res_valid, res_ready = 1'b0;
  logic [PW-1:0] res_p;
  logic          res_id, busy;

  int checks   = 0;
  int failures = 0;
  bit last_m   = 1'b1;

  sigmul_sched #(.NSIG(NSIG)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_p      (res_p),
    .res_id     (res_id),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One full transaction from IDLE: grant check, accept, latency, result,
  // optional hold in DONE, drain. exp0/exp1 are the products for each port.
  task automatic do_op(input bit v0, input bit v1,
                       input logic [SW-1:0] a0, input logic [SW-1:0] b0,
                       input logic [SW-1:0] a1, input logic [SW-1:0] b1,
                       input logic [PW-1:0] exp0, input logic [PW-1:0] exp1,
                       input int hold, input string tag);
    bit            g;
    logic [PW-1:0] expp;
    int            n;
    g    = (v0 && !v1) ? 1'b0 : (v1 && !v0) ? 1'b1 : !last_m;
    expp = g ? exp1 : exp0;
    req0_valid = v0; req1_valid = v1;
    req0_a = a0; req0_b = b0; req1_a = a1; req1_b = b1;
    res_ready = (hold == 0);
    #1;
    check({tag, "/rdy0"}, req0_ready, !g);
    check({tag, "/rdy1"}, req1_ready, g);
    @(posedge clk); #1;
    last_m = g;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = ~a0; req0_b = ~b0; req1_a = ~a1; req1_b = ~b1;
    check({tag, "/busy"}, busy, 1'b1);
    n = 0;
    while (!res_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "/latency"}, n, NSIG + 1);
    check({tag, "/p"}, res_p, expp);
    check({tag, "/id"}, res_id, g);
    for (int i = 0; i < hold; i++) begin
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      check({tag, "/hold_rdy0"}, req0_ready, 1'b0);
      check({tag, "/hold_rdy1"}, req1_ready, 1'b0);
      check({tag, "/hold_valid"}, res_valid, 1'b1);
      check({tag, "/hold_p"}, res_p, expp);
      check({tag, "/hold_id"}, res_id, g);
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    res_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "/drain_valid"}, res_valid, 1'b0);
    check({tag, "/drain_busy"}, busy, 1'b0);
  endtask

  initial begin
    int seen;
    logic [SW-1:0] ra0, rb0, ra1, rb1;
    int v;

    // Reset values with both valids asserted.
    req0_valid = 1'b1; req1_valid = 1'b1;
    #2;
    check("rst/rdy0", req0_ready, 1'b0);
    check("rst/rdy1", req1_ready, 1'b0);
    check("rst/valid", res_valid, 1'b0);
    check("rst/p", res_p, '0);
    check("rst/id", res_id, 1'b0);
    check("rst/busy", busy, 1'b0);
    @(posedge clk); #1;
    check("rst_edge/rdy0", req0_ready, 1'b0);
    check("rst_edge/busy", busy, 1'b0);
    #3 rst_n = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    @(posedge clk); #1;

    // Contention after reset: port 0 first, then port 1.
    do_op(1, 1, 11'h400, 11'h400, 11'h401, 11'h003, 22'h100000, 22'h000C03, 0, "cont_a");
    do_op(1, 1, 11'h400, 11'h400, 11'h401, 11'h003, 22'h100000, 22'h000C03, 0, "cont_b");
    // Continued contention alternates 0,1,0,1.
    for (int i = 0; i < 4; i++)
      do_op(1, 1, 11'h002, 11'h003, 11'h010, 11'h010, 22'h000006, 22'h000100, 0, "alt");

    // Single op, maximum operands.
    do_op(1, 0, 11'h7FF, 11'h7FF, 11'h000, 11'h000, 22'h3FF001, 22'h0, 0, "single");
    // Backpressure: five cycles with res_ready low.
    do_op(0, 1, 11'h000, 11'h000, 11'h100, 11'h00F, 22'h0, 22'h000F00, 5, "bp");
    // Zeros and identity.
    do_op(1, 0, 11'h5A5, 11'h000, 11'h000, 11'h000, 22'h000000, 22'h0, 0, "zero");
    do_op(1, 0, 11'h5A5, 11'h001, 11'h000, 11'h000, 22'h0005A5, 22'h0, 0, "ident");

    // Reset during MUL step 4 from a port-0 op (so last is 0 beforehand).
    req0_valid = 1'b1; req0_a = 11'h7FF; req0_b = 11'h7FF; res_ready = 1'b1;
    @(posedge clk); #1;
    req0_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst/valid", res_valid, 1'b0);
    check("midrst/p", res_p, '0);
    check("midrst/id", res_id, 1'b0);
    check("midrst/busy", busy, 1'b0);
    check("midrst/rdy0", req0_ready, 1'b0);
    @(posedge clk);
    #4 rst_n = 1'b1;
    last_m = 1'b1;
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (res_valid) seen++;
    end
    check("midrst/no_pulse", seen, 0);
    do_op(1, 1, 11'h003, 11'h005, 11'h7FF, 11'h002, 22'h00000F, 22'h000FFE, 0, "postrst");

    // Random traffic with idle gaps and random backpressure.
    for (int i = 0; i < 1000; i++) begin
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
      v   = $urandom_range(1, 3);
      ra0 = SW'($urandom); rb0 = SW'($urandom);
      ra1 = SW'($urandom); rb1 = SW'($urandom);
      do_op(v[0], v[1], ra0, rb0, ra1, rb1,
            PW'(ra0) * PW'(rb0), PW'(ra1) * PW'(rb1),
            $urandom_range(0, 3), "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sigmul_sched.md
# sigmul_sched

Sequential significand-multiply scheduler. It shares one shift-and-add significand multiplier between two requesters, port 0 and port 1, using round-robin arbitration. Each operand pair is multiplied over NSIG+1 cycles, and the full-width product is returned on a single result channel tagged with the requester id. It sits between the FP unpack stages of two pipelines and their exponent/normalise logic, where area matters more than throughput.

## Interface
- NSIG, default 10: stored fraction bits. Significands are NSIG+1 bits wide, including the hidden bit; products are 2*NSIG+2 bits wide.
- clk  input  1  sole clock, rising-edge.
- rst_n  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- req0_valid  input  1  port 0 holds an operand pair.
- req0_ready  output  1  port 0 pair accepted on this edge when req0_valid is also high.
- req0_a, req0_b  input  NSIG+1 each  port 0 significands.
- req1_valid, req1_ready, req1_a, req1_b: same as port 0, for port 1.
- res_valid  output  1  product available.
- res_ready  input  1  consumer accepts the product.
- res_p  output  2*NSIG+2  unsigned product a*b.
- res_id  output  1  requester that issued the product.
- busy  output  1  high in MUL or DONE.

## Operation
- FSM states: IDLE, MUL, DONE.
- **IDLE**
  - Grant rule: if exactly one reqN_valid is high, grant N. If both are high, grant the port other than `last`.
  - reqN_ready = (state==IDLE) & grant==N. It is combinational from the valids, `last` and state.
  - With no valid input, both readies are low.
- **Accept edge** (reqN_valid & reqN_ready):
  - Latch mcand=a and mplier=b; clear acc to 0; cnt=0; id=N; last=N.
  - Go to MUL.
- **MUL**: one step per edge.
  - If mplier[0], acc = acc + (mcand << cnt).
  - mplier >>= 1; cnt++.
  - After the step with cnt==NSIG, go to DONE.
  - Exactly NSIG+1 steps; no early termination.
- **DONE**
  - res_valid=1; res_p=acc; res_id=id.
  - res_valid & res_ready -> IDLE.
  - res_p and res_id are held stable while res_ready is low.
  - Both reqN_ready stay low in MUL and DONE.
- **Width**: acc is 2*NSIG+2 bits and never overflows, since (2^(NSIG+1)-1)^2 < 2^(2NSIG+2). The product is exact and unsigned; there is no rounding or normalisation here.
- **Boundaries**
  - An operand of 0 still takes the full NSIG+1 steps and yields 0.
  - Operand inputs are ignored outside the accept edge; the requester may change them freely afterwards.
  - A valid that drops before being granted is never served; no request is queued internally.
  - Starvation-free: with both ports continuously valid, grants alternate 0,1,0,1,...
- **Reset** (any time, including mid-MUL or in DONE):
  - Immediately state=IDLE, res_valid=0, res_p=0, res_id=0, busy=0, acc=0, cnt=0.
  - `last`=1, so port 0 wins the first contended grant.
  - An in-flight product is discarded and never presented.

## Timing
- Reset values: req0_ready=req1_ready=0 while rst_n is low; res_valid=0, res_p=0, res_id=0, busy=0.
- Accept on edge E0. MUL steps on E1..E(NSIG+1). res_valid is high after E(NSIG+1), i.e. NSIG+1 edges after accept (11 for NSIG=10).
- Result handshake on edge Ed returns to IDLE. A new accept is possible no earlier than Ed+1.
- Minimum initiation interval is NSIG+3 cycles (13 for NSIG=10).
- All outputs except reqN_ready are registered.

## Test plan
- Single op: port 0 sends a=0x7FF, b=0x7FF, res_ready=1.
  - Expect res_p=0x3FF001, res_id=0.
  - res_valid rises exactly 11 edges after accept, and the FSM is in IDLE one cycle later.
- Contention after reset: both ports valid on the same cycle, with port 0 a=0x400,b=0x400 and port 1 a=0x401,b=0x003.
  - Port 0 is served first: 0x100000, id 0.
  - Port 1 is served next: 0x000C03, id 1.
  - Continuous requests alternate 0,1,0,1.
- Backpressure: hold res_ready low for 5 cycles in DONE.
  - res_p and res_id are stable throughout; both reqN_ready stay 0.
  - Result drains on the first cycle res_ready=1.
- Zeros and identity: a=0x5A5, b=0 gives 0 after the full latency. a=0x5A5, b=0x001 gives 0x0005A5.
- Reset mid-op: assert rst_n low at MUL step 4 for 1 cycle.
  - All outputs are 0 asynchronously and no res_valid pulse occurs.
  - The next request completes correctly; port 0 wins if both are valid.
- Random: 1000 random operand pairs on both ports with random valid/res_ready gaps. Each product must equal the a*b scoreboard value and carry the correct id, in grant order.
